// File: rtl/read_gen_pkg.sv
// Shared definitions for the tile reader: FSM state encoding, tile pointer
// width and the return-FIFO depth rule.
package read_gen_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned TILE_PTR_W = 9;

  // Room for every in-flight word plus one full-throughput beat of slack.
  function automatic int unsigned fifo_depth(input int unsigned read_latency);
    return read_latency + 2;
  endfunction

endpackage

// File: rtl/read_gen_fifo.sv
// Small synchronous FIFO for returned BRAM words; head is combinationally
// visible and forced to zero while empty so the stream data idles at 0.
module read_gen_fifo
  import read_gen_pkg::*;
#(
  parameter int unsigned DEPTH      = fifo_depth(1),
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/read_logic_gen.sv
// Tile reader: issues one tile of BRAM reads under credit control and streams
// the returned words out. Define READ_LOGIC_TILE_WRAP_EN to wrap the tile
// pointer at NUM_TILES; otherwise it free-runs modulo 512.
module read_logic_gen
  import read_gen_pkg::*;
#(
  parameter int unsigned NUM_READS_PER_TILE = 2,
  parameter int unsigned ADDR_WIDTH         = 11,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned NUM_TILES          = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_read,
  input  logic                  reset_addr_counter,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  read_done,
  output logic                  busy
);

  localparam int unsigned DEPTH = fifo_depth(READ_LATENCY);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);
  localparam int unsigned SUM_W = ((CNT_W > LAT_W) ? CNT_W : LAT_W) + 1;
  localparam int unsigned OFF_W = $clog2(NUM_READS_PER_TILE + 1);

`ifdef READ_LOGIC_TILE_WRAP_EN
  localparam int unsigned TILE_COUNT = NUM_TILES;
`else
  // Free-running pointer: the full 9-bit range whatever NUM_TILES says.
  localparam int unsigned TILE_COUNT = (NUM_TILES > 0) ? (1 << TILE_PTR_W) : (1 << TILE_PTR_W);
`endif
  localparam logic [TILE_PTR_W-1:0] TILE_LAST = TILE_PTR_W'(TILE_COUNT - 1);

  logic [1:0]              state_q, state_d;
  logic [TILE_PTR_W-1:0]   tile_ptr_q, tile_ptr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [OFF_W-1:0]        offset_q, offset_d;
  logic [OFF_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;

  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic [LAT_W-1:0]        inflight;
  logic [SUM_W-1:0]        occupied;
  logic                    has_credit;
  logic                    beat_xfer;

  read_gen_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_sr_q[READ_LATENCY-1]),
    .pop_i   (beat_xfer),
    .wdata_i (bram_rdata),
    .rdata_o (rd_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + LAT_W'(vld_sr_q[i]);
    end
  end

  // A read may issue only if its word is guaranteed a FIFO slot on return.
  assign occupied   = SUM_W'(fifo_count) + SUM_W'(inflight);
  assign has_credit = (occupied < SUM_W'(DEPTH));

  assign rd_valid  = !fifo_empty;
  assign beat_xfer = rd_valid && rd_ready;
  assign rd_last   = rd_valid && (beat_cnt_q == OFF_W'(NUM_READS_PER_TILE - 1));
  assign bram_addr = base_q + ADDR_WIDTH'(offset_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_read) state_d = ST_ISSUE;
      ST_ISSUE: if (bram_en && offset_q == OFF_W'(NUM_READS_PER_TILE - 1)) state_d = ST_DRAIN;
      ST_DRAIN: if (beat_xfer && beat_cnt_q == OFF_W'(NUM_READS_PER_TILE - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bram_en   = (state_q == ST_ISSUE) && has_credit;
    read_done = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  always_comb begin
    tile_ptr_d = tile_ptr_q;
    base_d     = base_q;
    offset_d   = offset_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == ST_IDLE && start_read) begin
      base_d     = ADDR_WIDTH'(int'(tile_ptr_q) * int'(NUM_READS_PER_TILE));
      offset_d   = '0;
      beat_cnt_d = '0;
    end
    if (bram_en) offset_d = offset_q + 1'b1;
    if (beat_xfer) beat_cnt_d = beat_cnt_q + 1'b1;
    if (state_q == ST_DONE) tile_ptr_d = (tile_ptr_q == TILE_LAST) ? '0 : tile_ptr_q + 1'b1;
    if (reset_addr_counter) tile_ptr_d = '0;
    vld_sr_d = (vld_sr_q << 1) | READ_LATENCY'(bram_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_ptr_q <= '0;
      base_q     <= '0;
      offset_q   <= '0;
      beat_cnt_q <= '0;
      vld_sr_q   <= '0;
    end else begin
      tile_ptr_q <= tile_ptr_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      beat_cnt_q <= beat_cnt_d;
      vld_sr_q   <= vld_sr_d;
    end
  end

endmodule

// File: tb/tb_read_logic_gen.sv
// Directed-plus-random bench for read_logic_gen with a behavioural BRAM and a
// queue-based model of the expected address and data stream per tile.
module tb_read_logic_gen;

  localparam int N   = 8;
  localparam int LAT = 2;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int NT  = 4;
`ifdef READ_LOGIC_TILE_WRAP_EN
  localparam int TILE_MOD = NT;
`else
  localparam int TILE_MOD = 512;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_read;
  logic          reset_addr_counter;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          read_done;
  logic          busy;

  always #5 clk = ~clk;

  read_logic_gen #(
    .NUM_READS_PER_TILE (N),
    .ADDR_WIDTH         (AW),
    .DATA_WIDTH         (DW),
    .READ_LATENCY       (LAT),
    .NUM_TILES          (NT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start_read         (start_read),
    .reset_addr_counter (reset_addr_counter),
    .bram_addr          (bram_addr),
    .bram_en            (bram_en),
    .bram_rdata         (bram_rdata),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_last            (rd_last),
    .read_done          (read_done),
    .busy               (busy)
  );

  // Behavioural BRAM: random contents, LAT-cycle read pipeline, junk when idle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= bram_en ? mem[bram_addr] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rdata = pipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int tile_m = 0;
  int exp_addr[$];
  logic [DW-1:0] exp_data[$];
  bit exp_last[$];
  int en_cnt = 0, done_cnt = 0;
  int first_en = -1, last_en = -1, first_valid = -1, done_cyc = -1;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", 64'(rd_valid), 64'(1));
      chk("hold_data", 64'(rd_data), 64'(prev_data));
    end
    if (bram_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc - c0;
      last_en = cyc - c0;
      chk("read_expected", 64'(exp_addr.size() > 0), 64'(1));
      if (exp_addr.size() > 0) chk("bram_addr", 64'(bram_addr), 64'(exp_addr.pop_front()));
    end
    if (rd_valid && first_valid < 0) first_valid = cyc - c0;
    if (rd_valid && rd_ready) begin
      chk("beat_expected", 64'(exp_data.size() > 0), 64'(1));
      if (exp_data.size() > 0) begin
        chk("rd_data", 64'(rd_data), 64'(exp_data.pop_front()));
        chk("rd_last", 64'(rd_last), 64'(exp_last.pop_front()));
      end
    end
    if (read_done) begin
      done_cnt++;
      done_cyc = cyc - c0;
    end
    prev_stall = rd_valid && !rd_ready && !rst;
    prev_data  = rd_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_expected();
    int base;
    base = (tile_m * N) % (1 << AW);
    for (int k = 0; k < N; k++) begin
      exp_addr.push_back((base + k) % (1 << AW));
      exp_data.push_back(mem[(base + k) % (1 << AW)]);
      exp_last.push_back(k == N - 1);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for cycles 0..10.
  task automatic run_tile(input int mode, input bit rac_at_done, input bit extra_start);
    int rel;
    int base;
    base = (tile_m * N) % (1 << AW);
    push_expected();
    en_cnt = 0; done_cnt = 0;
    first_en = -1; last_en = -1; first_valid = -1; done_cyc = -1;
    c0 = cyc;
    start_read = 1'b1;
    rd_ready = (mode == 2) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start_read = 1'b0;
    for (int b = 0; b < 400 && done_cnt == 0; b++) begin
      rel = cyc - c0;
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (rel > 10);
      start_read = extra_start && (rel == 3);
      reset_addr_counter = rac_at_done && (rel == N + LAT + 2);
      if (rel == 1) chk("busy_run", 64'(busy), 64'(1));
      if (mode == 2 && rel == 11) chk("bp_reads", 64'(en_cnt), 64'(4));
      tick();
    end
    start_read = 1'b0;
    reset_addr_counter = 1'b0;
    rd_ready = 1'b1;
    tick();
    tick();
    chk("busy_idle", 64'(busy), 64'(0));
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("reads", 64'(en_cnt), 64'(N));
    chk("beats_left", 64'(exp_data.size()), 64'(0));
    chk("addrs_left", 64'(exp_addr.size()), 64'(0));
    if (mode == 0) begin
      chk("first_en_cyc", 64'(first_en), 64'(1));
      chk("last_en_cyc", 64'(last_en), 64'(N));
      chk("first_valid_cyc", 64'(first_valid), 64'(LAT + 2));
      chk("done_cyc", 64'(done_cyc), 64'(N + LAT + 2));
    end
    $display("tile base=%0d mode=%0d reads=%0d done_cycle=%0d", base, mode, en_cnt, done_cyc);
    tile_m = rac_at_done ? 0 : (tile_m + 1) % TILE_MOD;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    rst = 1'b1;
    start_read = 1'b0;
    reset_addr_counter = 1'b0;
    rd_ready = 1'b1;
    repeat (3) tick();
    chk("rst_addr", 64'(bram_addr), 64'(0));
    chk("rst_en", 64'(bram_en), 64'(0));
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_data", 64'(rd_data), 64'(0));
    chk("rst_done", 64'(read_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    tick();

    // Two plain tiles, backpressure, then randomly throttled consumer.
    run_tile(0, 1'b0, 1'b0);
    run_tile(0, 1'b0, 1'b0);
    run_tile(2, 1'b0, 1'b0);
    run_tile(1, 1'b0, 1'b0);
    run_tile(1, 1'b0, 1'b0);

    // Pointer reset coincident with DONE, then the next tile starts at 0.
    run_tile(0, 1'b1, 1'b0);
    run_tile(0, 1'b0, 1'b0);

    // start_read during ISSUE must be ignored.
    run_tile(0, 1'b0, 1'b1);

    // Reset in the middle of a tile.
    push_expected();
    en_cnt = 0;
    c0 = cyc;
    start_read = 1'b1;
    rd_ready = 1'b0;
    tick();
    start_read = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_addr", 64'(bram_addr), 64'(0));
    chk("mid_rst_en", 64'(bram_en), 64'(0));
    chk("mid_rst_valid", 64'(rd_valid), 64'(0));
    chk("mid_rst_data", 64'(rd_data), 64'(0));
    chk("mid_rst_last", 64'(rd_last), 64'(0));
    chk("mid_rst_done", 64'(read_done), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
    tile_m = 0;
    rd_ready = 1'b1;
    repeat (6) tick();
    chk("mid_rst_reads", 64'(en_cnt), 64'(4));

    // Five tiles from tile 0: exercises the wrap when enabled.
    for (int t = 0; t < 5; t++) run_tile((t == 2) ? 1 : 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/read_logic_gen.md
# read_logic_gen

- Read-side counterpart of the tile writer.
- On each `start_read` pulse, it issues `NUM_READS_PER_TILE` consecutive BRAM reads for the current tile and absorbs the fixed BRAM read latency.
- Returned words go out on a valid/ready stream with a last-beat flag; credit-based issue means no word is ever dropped under backpressure.
- Sits between the arbiter's BRAM read port and the compute-side consumer, using the same tile-major address map as the writer: `addr = tile*NUM_READS_PER_TILE + offset`.

## Interface
Parameters:
- `NUM_READS_PER_TILE`, 2, words per tile (≥1)
- `ADDR_WIDTH`, 11, BRAM address width
- `DATA_WIDTH`, 32, BRAM word width
- `READ_LATENCY`, 1, BRAM cycles from `bram_en` to valid `bram_rdata` (1..4)
- `NUM_TILES`, 512, tile count; used only with the wrap feature

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start_read`  in  1  pulse: begin reading the next tile
- `reset_addr_counter`  in  1  pulse: tile pointer ← 0
- `bram_addr`  out  ADDR_WIDTH  read address
- `bram_en`  out  1  read enable, one read per high cycle
- `bram_rdata`  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after `bram_en`
- `rd_data`  out  DATA_WIDTH  stream data (FIFO head)
- `rd_valid`  out  1  stream valid
- `rd_ready`  in  1  consumer ready; a beat transfers when valid&ready
- `rd_last`  out  1  high with the final beat of the tile
- `read_done`  out  1  one-cycle pulse once every beat of the tile has transferred
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - On `start_read`: latch `base = tile_ptr*NUM_READS_PER_TILE` (truncated to ADDR_WIDTH), set offset←0, go to ISSUE.
  - `start_read` is ignored in every other state.
- **ISSUE**
  - `bram_en=1` iff `credits>0`, where `credits = FIFO_DEPTH − fifo_count − inflight` and `FIFO_DEPTH = READ_LATENCY+2`.
  - `bram_addr = base + offset` (mod 2^ADDR_WIDTH).
  - Offset increments on each issued read. Go to DRAIN after the read at `offset = NUM_READS_PER_TILE−1`.
- **Returned data**
  - A READ_LATENCY-deep valid shift register tracks issued reads.
  - Its output pushes `bram_rdata` into the FIFO; push never occurs when full, which is guaranteed by credits.
  - `inflight` is the popcount of the shift register.
- **Last-beat tracking**
  - A beat counter counts transferred beats.
  - `rd_last = rd_valid & (beat_cnt == NUM_READS_PER_TILE−1)`.
- **DRAIN**
  - Go to DONE when `beat_cnt` reaches `NUM_READS_PER_TILE`, i.e. FIFO empty and inflight=0.
- **DONE**
  - `read_done=1` for one cycle; tile_ptr increments; next state IDLE.
- **reset_addr_counter**
  - Sets tile_ptr←0 and wins over the DONE increment.
  - Mid-tile it does not disturb the latched base; it affects the next tile only.
- **Reset**
  - State IDLE; tile_ptr, offset, beat_cnt, FIFO, shift register all cleared.
  - All outputs 0, including `bram_addr`.
  - Reset mid-tile discards all in-flight data; late `bram_rdata` is ignored.
- **Address outside ISSUE**
  - `bram_addr` holds `base+offset` and is don't-care when `bram_en=0`.

## Timing
- `start_read` sampled at edge 0 → first `bram_en` in cycle 1.
- With `rd_ready` held high, one read issues per cycle.
- First `rd_valid` appears in cycle `1+READ_LATENCY+1`.
- FIFO: push at edge, head visible next cycle; pop and push may occur in the same cycle.
- With `rd_ready=1` throughout, `read_done` is high in the cycle after the last beat transfers: cycle `NUM_READS_PER_TILE+READ_LATENCY+2`.
- Back-to-back tiles: `start_read` may be asserted in the DONE cycle, but it is only accepted in IDLE.
  - Minimum gap between tiles is therefore one IDLE cycle.
- `rd_ready` low: issue stalls once `credits=0`; `rd_valid`/`rd_data` remain stable until accepted.

## Configuration
- Macro `READ_LOGIC_TILE_WRAP_EN`.
- **Defined:** tile_ptr wraps from `NUM_TILES−1` to 0 at DONE.
- **Undefined:** tile_ptr is 9 bits and free-runs modulo 512; `NUM_TILES` is unused.

## Structure
- **Package `read_gen_pkg`:**
  - State encoding localparams (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
  - `FIFO_DEPTH` formula
  - Tile pointer width (9)
- **Sub-module `read_gen_fifo`:** synchronous FIFO with depth `READ_LATENCY+2`, width `DATA_WIDTH`, and a count output. Count width is the clog2 of `depth+1`.

## Test plan
- **Single tile, default parameters:** `rst`, then `start_read`.
  - `bram_addr` 0,1 on cycles 1,2.
  - Consumer sees data words 0 and 1; `rd_last` on the second.
  - `read_done` pulses once; the next tile reads addresses 2,3.
- **Backpressure, `READ_LATENCY=2`:** `rd_ready=0` for 10 cycles, `NUM_READS_PER_TILE=8`.
  - Exactly 4 reads issue, then `bram_en` stays low.
  - After `rd_ready=1`, all 8 words arrive in order with none lost.
- **Pointer reset:** 3 tiles, then `reset_addr_counter` coincident with DONE → next tile reads address 0.
- **Busy:** `start_read` pulsed during ISSUE → ignored; exactly `NUM_READS_PER_TILE` reads and one `read_done`.
- **Reset mid-tile:** `rst` asserted mid-ISSUE.
  - Next cycle: all outputs 0, FIFO empty.
  - A subsequent `start_read` reads from tile 0.
- **Wrap, `READ_LOGIC_TILE_WRAP_EN` defined, `NUM_TILES=4`:** 5 tiles → the fifth tile's base address is 0.
